cond_ctrl_pipe: RTL and testbench

- Decode stage control unit for the ARM core: decodes mode/opcode/S/I and evaluates the ARM condition field against the status flags.
- Registers the resulting control bundle into the ID/EX boundary, so latency is 1 cycle.
- Honours hazard freeze and flush.
- Sequences branch-shadow bubbles and multi-cycle memory waits with a small FSM.
- Sits between the IF/ID register and the ID/EX register; feeds EXE, MEM and WB enables.

---
 rtl/arm_ctrl_pkg.sv | 73 +++++++
 rtl/cond_ctrl_pipe_cond_check.sv | 36 +++
 rtl/cond_ctrl_pipe.sv | 199 +++++++++++++++++++
 tb/tb_cond_ctrl_pipe.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the decode-stage control path: modes, ARM opcodes,
// ALU commands, condition codes, FSM states and the registered control bundle.
package arm_ctrl_pkg;

  localparam logic [1:0] MODE_ARITH  = 2'b00;
  localparam logic [1:0] MODE_MEM    = 2'b01;
  localparam logic [1:0] MODE_BRANCH = 2'b10;
  localparam logic [1:0] MODE_COPROC = 2'b11;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_RSB = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_RSC = 4'b0111;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_TEQ = 4'b1001;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_CMN = 4'b1011;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_BIC = 4'b1110;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam logic [3:0] CMD_NOP = 4'b0000;
  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_BR_SHADOW = 2'b01,
    ST_MEM_WAIT  = 2'b10
  } ctrl_state_t;

  typedef struct packed {
    logic [3:0] cmd;
    logic       mem_r;
    logic       mem_w;
    logic       wb;
    logic       status_w;
    logic       branch;
    logic       imm;
    logic       valid;
    logic       illegal;
  } ctrl_bundle_t;

endpackage

// File: rtl/cond_ctrl_pipe_cond_check.sv
// ARM condition-field evaluator: combinational cond + {N,Z,C,V} -> pass.
// cond=1111 (NV) never passes.
module cond_check
  import arm_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_ctrl_pipe.sv
// Decode-stage control unit: decodes mode/opcode/S/I, registers the control
// bundle into ID/EX. Define COND_EXEC_EN for full ARM condition evaluation.
module cond_ctrl_pipe
  import arm_ctrl_pkg::*;
#(
  parameter int unsigned CMD_W             = 4,
  parameter int unsigned FLUSH_CYCLES      = 1,
  parameter int unsigned MEM_WAIT_EN_DEPTH = 3
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [3:0]       cond,
  input  logic [1:0]       mode,
  input  logic [3:0]       opcode,
  input  logic             s,
  input  logic             imm_in,
  input  logic [3:0]       sr_flags,
  input  logic             freeze,
  input  logic             flush,
  input  logic             mem_done,
  output logic [CMD_W-1:0] exec_cmd,
  output logic             mem_r_en,
  output logic             mem_w_en,
  output logic             wb_en,
  output logic             status_w_en,
  output logic             branch_taken,
  output logic             imm,
  output logic             out_valid,
  output logic             busy,
  output logic             illegal_op,
  output logic             mem_timeout
);

  localparam logic [2:0] SHADOW_LAST = 3'(FLUSH_CYCLES - 1);
  localparam logic [MEM_WAIT_EN_DEPTH-1:0] WAIT_LAST =
    MEM_WAIT_EN_DEPTH'((1 << MEM_WAIT_EN_DEPTH) - 2);

  ctrl_state_t                  state, state_nxt;
  logic [2:0]                   shadow_cnt;
  logic [MEM_WAIT_EN_DEPTH-1:0] wait_cnt;
  logic                         cond_pass;
  logic                         wait_expired;
  logic                         nxt_timeout;
  ctrl_bundle_t                 dec, nxt;

`ifdef COND_EXEC_EN
  cond_check u_cond_check (
    .cond  (cond),
    .flags (sr_flags),
    .pass  (cond_pass)
  );
`else
  logic unused_cond_inputs;
  assign unused_cond_inputs = ^{cond, sr_flags};
  assign cond_pass = 1'b1;
`endif

  always_comb begin
    dec     = '0;
    dec.cmd = CMD_NOP;
    if (in_valid && cond_pass) begin
      unique case (mode)
        MODE_ARITH: begin
          dec.valid    = 1'b1;
          dec.imm      = imm_in;
          dec.wb       = 1'b1;
          dec.status_w = s;
          case (opcode)
            OP_MOV: dec.cmd = CMD_MOV;
            OP_MVN: dec.cmd = CMD_MVN;
            OP_ADD: dec.cmd = CMD_ADD;
            OP_ADC: dec.cmd = CMD_ADC;
            OP_SUB: dec.cmd = CMD_SUB;
            OP_SBC: dec.cmd = CMD_SBC;
            OP_AND: dec.cmd = CMD_AND;
            OP_ORR: dec.cmd = CMD_ORR;
            OP_EOR: dec.cmd = CMD_EOR;
            OP_CMP: begin
              dec.cmd      = CMD_SUB;
              dec.wb       = 1'b0;
              dec.status_w = 1'b1;
            end
            OP_TST: begin
              dec.cmd      = CMD_AND;
              dec.wb       = 1'b0;
              dec.status_w = 1'b1;
            end
            default: begin
              dec         = '0;
              dec.illegal = 1'b1;
            end
          endcase
        end
        MODE_MEM: begin
          dec.valid = 1'b1;
          dec.imm   = imm_in;
          dec.cmd   = CMD_ADD;
          dec.mem_r = s;
          dec.wb    = s;
          dec.mem_w = !s;
        end
        MODE_BRANCH: begin
          dec.valid  = 1'b1;
          dec.imm    = imm_in;
          dec.branch = 1'b1;
        end
        MODE_COPROC: dec.illegal = 1'b1;
      endcase
    end
  end

  assign wait_expired = (state == ST_MEM_WAIT) && !mem_done && (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_IDLE;
    end else if (!freeze) begin
      unique case (state)
        ST_IDLE: begin
          if (dec.branch)                  state_nxt = ST_BR_SHADOW;
          else if (dec.mem_r || dec.mem_w) state_nxt = ST_MEM_WAIT;
        end
        ST_BR_SHADOW: if (shadow_cnt == SHADOW_LAST)    state_nxt = ST_IDLE;
        ST_MEM_WAIT:  if (mem_done || wait_expired)     state_nxt = ST_IDLE;
        default:      state_nxt = ST_IDLE;
      endcase
    end
  end

  // Anything presented outside IDLE is squashed; only IDLE passes decode through.
  always_comb begin
    nxt         = '0;
    nxt.cmd     = CMD_NOP;
    nxt_timeout = 1'b0;
    if (state == ST_IDLE) nxt = dec;
    else                  nxt_timeout = wait_expired;
  end

  // Counters restart from zero on every IDLE edge, so entry always begins at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_cnt <= '0;
      wait_cnt   <= '0;
    end else if (flush) begin
      shadow_cnt <= '0;
      wait_cnt   <= '0;
    end else if (!freeze) begin
      shadow_cnt <= (state == ST_BR_SHADOW) ? shadow_cnt + 3'd1 : '0;
      wait_cnt   <= (state == ST_MEM_WAIT)  ? wait_cnt + 1'b1   : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exec_cmd     <= CMD_W'(CMD_NOP);
      mem_r_en     <= 1'b0;
      mem_w_en     <= 1'b0;
      wb_en        <= 1'b0;
      status_w_en  <= 1'b0;
      branch_taken <= 1'b0;
      imm          <= 1'b0;
      out_valid    <= 1'b0;
      illegal_op   <= 1'b0;
      mem_timeout  <= 1'b0;
    end else if (flush) begin
      exec_cmd     <= CMD_W'(CMD_NOP);
      mem_r_en     <= 1'b0;
      mem_w_en     <= 1'b0;
      wb_en        <= 1'b0;
      status_w_en  <= 1'b0;
      branch_taken <= 1'b0;
      imm          <= 1'b0;
      out_valid    <= 1'b0;
      illegal_op   <= 1'b0;
      mem_timeout  <= 1'b0;
    end else if (!freeze) begin
      exec_cmd     <= CMD_W'(nxt.cmd);
      mem_r_en     <= nxt.mem_r;
      mem_w_en     <= nxt.mem_w;
      wb_en        <= nxt.wb;
      status_w_en  <= nxt.status_w;
      branch_taken <= nxt.branch;
      imm          <= nxt.imm;
      out_valid    <= nxt.valid;
      illegal_op   <= nxt.illegal;
      mem_timeout  <= nxt_timeout;
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_cond_ctrl_pipe.sv
// Scoreboard bench for cond_ctrl_pipe: a behavioural model predicts each
// registered bundle; a monitor compares one bundle per clock.
module tb_cond_ctrl_pipe;

  localparam int FLUSH = 2;
  localparam int DEPTH = 3;
  localparam int TMO   = (1 << DEPTH) - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] cond = 4'hE;
  logic [1:0] mode = 2'b00;
  logic [3:0] opcode = 4'h0;
  logic       s = 1'b0;
  logic       imm_in = 1'b0;
  logic [3:0] sr_flags = 4'h0;
  logic       freeze = 1'b0;
  logic       flush = 1'b0;
  logic       mem_done = 1'b0;
  logic [3:0] exec_cmd;
  logic       mem_r_en, mem_w_en, wb_en, status_w_en, branch_taken, imm;
  logic       out_valid, busy, illegal_op, mem_timeout;

  always #5 clk = ~clk;

  cond_ctrl_pipe #(
    .CMD_W             (4),
    .FLUSH_CYCLES      (FLUSH),
    .MEM_WAIT_EN_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .cond         (cond),
    .mode         (mode),
    .opcode       (opcode),
    .s            (s),
    .imm_in       (imm_in),
    .sr_flags     (sr_flags),
    .freeze       (freeze),
    .flush        (flush),
    .mem_done     (mem_done),
    .exec_cmd     (exec_cmd),
    .mem_r_en     (mem_r_en),
    .mem_w_en     (mem_w_en),
    .wb_en        (wb_en),
    .status_w_en  (status_w_en),
    .branch_taken (branch_taken),
    .imm          (imm),
    .out_valid    (out_valid),
    .busy         (busy),
    .illegal_op   (illegal_op),
    .mem_timeout  (mem_timeout)
  );

  typedef struct packed {
    logic [3:0] cmd;
    logic mr, mw, wb, sw, br, imm, ov, busy, ill, tmo;
  } obs_t;

  obs_t        exp_q[$];
  int unsigned tests = 0;
  int unsigned fails = 0;

  // Model state: remaining shadow bubbles, pending memory access and its age.
  int   shadow_left = 0;
  bit   in_wait     = 0;
  int   wait_cnt    = 0;
  obs_t last        = '0;

  // ALU command per ARM opcode index; -1 marks an undefined opcode.
  int arith_cmd [16] = '{6, 8, 4, -1, 2, 3, 5, -1, 6, -1, 4, -1, 7, 1, -1, 9};

  function automatic obs_t actual();
    return {exec_cmd, mem_r_en, mem_w_en, wb_en, status_w_en, branch_taken,
            imm, out_valid, busy, illegal_op, mem_timeout};
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %b want %b (cmd mr mw wb sw br imm ov busy ill tmo) at %0t",
               name, got, want, $time);
    end
  endtask

  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
`ifdef COND_EXEC_EN
    bit n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cf;
      4'd3:  return !cf;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cf && !z;
      4'd9:  return !cf || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
`else
    return 1'b1;
`endif
  endfunction

  function automatic obs_t decode();
    obs_t o;
    int   code;
    o = '0;
    if (!in_valid || !cond_ok(cond, sr_flags)) return o;
    if (mode == 2'b00) begin
      code = arith_cmd[opcode];
      if (code < 0) begin
        o.ill = 1'b1;
        return o;
      end
      o.cmd = code[3:0];
      o.ov  = 1'b1;
      o.imm = imm_in;
      if (opcode == 4'd8 || opcode == 4'd10) o.sw = 1'b1;
      else begin
        o.wb = 1'b1;
        o.sw = s;
      end
    end else if (mode == 2'b01) begin
      o.cmd = 4'b0010;
      o.ov  = 1'b1;
      o.imm = imm_in;
      o.mr  = s;
      o.wb  = s;
      o.mw  = !s;
    end else if (mode == 2'b10) begin
      o.br  = 1'b1;
      o.ov  = 1'b1;
      o.imm = imm_in;
    end else begin
      o.ill = 1'b1;
    end
    return o;
  endfunction

  task automatic model_step(output obs_t o);
    o = '0;
    if (flush) begin
      shadow_left = 0;
      in_wait     = 0;
    end else if (freeze) begin
      o = last;
    end else if (shadow_left > 0) begin
      shadow_left--;
    end else if (in_wait) begin
      if (mem_done) in_wait = 0;
      else begin
        wait_cnt++;
        if (wait_cnt == TMO) begin
          in_wait = 0;
          o.tmo   = 1'b1;
        end
      end
    end else begin
      o = decode();
      if (o.br) shadow_left = FLUSH;
      if (o.mr || o.mw) begin
        in_wait  = 1;
        wait_cnt = 0;
      end
    end
    if (flush || !freeze) o.busy = (shadow_left > 0) || in_wait;
    last = o;
  endtask

  task automatic model_reset();
    shadow_left = 0;
    in_wait     = 0;
    wait_cnt    = 0;
    last        = '0;
  endtask

  task automatic drive(input logic v, input logic [3:0] c, input logic [1:0] m,
                       input logic [3:0] op, input logic sb, input logic ib,
                       input logic [3:0] f, input logic fr, input logic fl,
                       input logic md);
    obs_t e;
    @(negedge clk);
    in_valid = v;  cond = c;    mode = m;     opcode = op;
    s = sb;        imm_in = ib; sr_flags = f;
    freeze = fr;   flush = fl;  mem_done = md;
    model_step(e);
    exp_q.push_back(e);
  endtask

  task automatic idle(input logic md);
    drive(1'b0, 4'hE, 2'b00, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, md);
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) idle(1'b0);
  endtask

  always @(posedge clk) begin
    obs_t e;
    #2;
    if (!rst && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("bundle", actual(), e);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1);
  end

  initial begin
    logic [3:0] rc;
    logic [1:0] rm;
    rst = 1'b1;
    @(posedge clk);
    #2;
    check("reset_state", actual(), '0);
    @(negedge clk);
    rst = 1'b0;

    // ADD AL s=1, then CMP s=0, TST, an undefined opcode and a co-processor op
    drive(1, 4'hE, 2'b00, 4'b0100, 1, 0, 4'h0, 0, 0, 0);
    drive(1, 4'hE, 2'b00, 4'b1010, 0, 1, 4'h0, 0, 0, 0);
    drive(1, 4'hE, 2'b00, 4'b1000, 0, 0, 4'h0, 0, 0, 0);
    drive(1, 4'hE, 2'b00, 4'b0011, 1, 1, 4'h0, 0, 0, 0);
    drive(1, 4'hE, 2'b11, 4'b0000, 0, 0, 4'h0, 0, 0, 0);
    // MOV EQ with Z=0 then Z=1; NV condition
    drive(1, 4'h0, 2'b00, 4'b1101, 0, 0, 4'b0000, 0, 0, 0);
    drive(1, 4'h0, 2'b00, 4'b1101, 0, 0, 4'b0100, 0, 0, 0);
    drive(1, 4'hF, 2'b00, 4'b1101, 0, 0, 4'b0100, 0, 0, 0);
    // branch, then instructions (including a branch) presented during the shadow
    drive(1, 4'hE, 2'b10, 4'h0, 0, 1, 4'h0, 0, 0, 0);
    drive(1, 4'hE, 2'b00, 4'b0100, 1, 0, 4'h0, 0, 0, 0);
    drive(1, 4'hE, 2'b10, 4'h0, 0, 0, 4'h0, 0, 0, 0);
    drive(1, 4'hE, 2'b00, 4'b0100, 1, 0, 4'h0, 0, 0, 0);
    // LDR with mem_done on the second wait cycle; mem_done in IDLE ignored
    drive(1, 4'hE, 2'b01, 4'h0, 1, 1, 4'h0, 0, 0, 0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);
    // STR with no mem_done: timeout
    drive(1, 4'hE, 2'b01, 4'h0, 0, 0, 4'h0, 0, 0, 0);
    idle_n(TMO + 2);
    // freeze during a valid SUB
    drive(1, 4'hE, 2'b00, 4'b0010, 1, 1, 4'h0, 0, 0, 0);
    drive(1, 4'hE, 2'b00, 4'b1101, 0, 0, 4'h0, 1, 0, 0);
    drive(1, 4'hE, 2'b10, 4'h0, 0, 0, 4'h0, 1, 0, 0);
    drive(1, 4'hE, 2'b00, 4'b0100, 0, 0, 4'h0, 1, 0, 0);
    idle(1'b0);
    // flush with a valid instruction, then flush mid-wait
    drive(1, 4'hE, 2'b00, 4'b0100, 1, 0, 4'h0, 0, 1, 0);
    drive(1, 4'hE, 2'b01, 4'h0, 1, 0, 4'h0, 0, 0, 0);
    idle(1'b0);
    drive(1, 4'hE, 2'b00, 4'b0100, 1, 0, 4'h0, 1, 1, 0);
    drive(1, 4'hE, 2'b00, 4'b0100, 1, 0, 4'h0, 0, 0, 0);

    // asynchronous reset mid MEM_WAIT
    drive(1, 4'hE, 2'b01, 4'h0, 1, 0, 4'h0, 0, 0, 0);
    idle_n(3);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("async_reset", actual(), '0);
    exp_q.delete();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(1'b0);

    for (int i = 0; i < 800; i++) begin
      rc = ($urandom_range(0, 1) == 0) ? 4'hE : 4'($urandom_range(0, 15));
      rm = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      drive($urandom_range(0, 99) < 85, rc, rm, 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), $urandom_range(0, 99) < 10,
            $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 30);
    end

    idle_n(4);
    @(posedge clk);
    #3;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending bundles want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
